alu_share_arbiter: RTL and testbench

Shares one multi-cycle ALU (mulu/divu/and/or; valid-in pulse, ready-out pulse, 64-bit result) among NUM_REQ requesters. It grants requesters round-robin, latches the winner's operands, and issues a single-cycle valid to the ALU. It then waits for the ALU ready pulse, with a timeout watchdog, and returns the 64-bit result to the owner through a valid/ack response handshake. It sits between the requesting units and the single ALU instance; the ALU shares clk/rst_n.

---
 rtl/alu_share_arbiter_pkg.sv | 29 ++
 rtl/alu_share_arbiter_rr.sv | 39 +++
 rtl/alu_share_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter slice.
// Contents:
//   - ALU op-code constants (mulu, divu, and, or).
//   - ALU valid-to-ready latencies for each op class.
//   - Default watchdog limit for the WAIT state.
//   - The arbiter FSM state encoding.
package alu_share_arbiter_pkg;

  localparam logic [1:0] OP_MULU = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_OR   = 2'd3;

  // Cycles from alu_valid to alu_ready for each op class.
  localparam int ALU_LAT_MULDIV = 33;
  localparam int ALU_LAT_LOGIC  = 2;

  // Must stay above ALU_LAT_MULDIV, or a healthy divide would be reported
  // as a timeout.
  localparam int DEFAULT_TIMEOUT = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin arbiter. Purely combinational.
// The search starts at rr_ptr and wraps modulo NUM_REQ. The first set request
// bit wins.
// Ports:
//   req       in   NUM_REQ  request vector
//   rr_ptr    in   PTR_W    highest-priority index for this decision
//   grant     out  NUM_REQ  one-hot grant, zero when no request is set
//   grant_idx out  PTR_W    encoded index of the granted requester
//   grant_any out  1        some requester was granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Two passes give the wrap-around order with only constant loop indices.
  // Pass 0 covers indices rr_ptr..NUM_REQ-1. Pass 1 covers 0..rr_ptr-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req[i] &&
            ((pass == 0) ? (i >= int'(rr_ptr)) : (i < int'(rr_ptr)))) begin
          grant[i]  = 1'b1;
          grant_idx = PTR_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one multi-cycle ALU among NUM_REQ requesters.
// Operation:
//   - Requests are granted round-robin, and the winner's operands are latched.
//   - A one-cycle alu_valid starts the ALU.
//   - The block waits for alu_ready, guarded by a TIMEOUT-cycle watchdog.
//   - The 64-bit result (or a timeout error completion) goes back to the
//     owner over a valid/ack handshake.
// Ports:
//   clk, rst_n            clock; async active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot)
//   req_mode/req_a/req_b  per-requester op and operands, packed by index
//   rsp_valid/rsp_ack     per-requester response handshake (valid one-hot)
//   rsp_data, rsp_err     result for the owner; rsp_err marks a timeout
//   err_sticky            set by any timeout, cleared only by reset
//   busy                  high outside IDLE
//   alu_valid, alu_mode, alu_in_a, alu_in_b   ALU start and latched operands
//   alu_ready, alu_out    ALU completion pulse and result
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_mode,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ack,
  output logic [63:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    err_sticky,
  output logic                    busy,
  output logic                    alu_valid,
  output logic [1:0]              alu_mode,
  output logic [31:0]             alu_in_a,
  output logic [31:0]             alu_in_b,
  input  logic                    alu_ready,
  input  logic [63:0]             alu_out
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, owner, grant_idx;
  logic [NUM_REQ-1:0] grant, owner_oh;
  logic               grant_any, owner_ack, timed_out;
  logic [1:0]         mode_q, sel_mode;
  logic [31:0]        a_q, b_q, sel_a, sel_b;
  logic [63:0]        rsp_data_q;
  logic               rsp_err_q, err_sticky_q;
  logic [TMR_W-1:0]   timer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Only the owner's ack bit counts. Acks on other bits are ignored.
  assign owner_oh  = NUM_REQ'(1) << owner;
  assign owner_ack = |(rsp_ack & owner_oh);
  assign timed_out = (timer == TMR_LAST);

  // One-hot mux selects the winner's op and operands for latching.
  always_comb begin
    sel_mode = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_mode = req_mode[2*i +: 2];
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A grant in IDLE is itself the transfer, since the arbiter only grants
  // requesters whose req_valid is set.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (grant_any) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (alu_ready || timed_out) state_next = ST_RESP;
      ST_RESP:  if (owner_ack) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    alu_valid = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:  req_ready = grant;
      ST_ISSUE: alu_valid = 1'b1;
      ST_RESP:  rsp_valid = owner_oh;
      default:  ;
    endcase
  end

  // Datapath registers: operand latches, watchdog timer, response, pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      owner        <= '0;
      mode_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      timer        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner  <= grant_idx;
            mode_q <= sel_mode;
            a_q    <= sel_a;
            b_q    <= sel_b;
          end
        end
        ST_ISSUE: timer <= '0;
        ST_WAIT: begin
          if (alu_ready) begin
            rsp_data_q <= alu_out;
            rsp_err_q  <= 1'b0;
          end else if (timed_out) begin
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          // The requester just served moves to lowest priority.
          if (owner_ack) rr_ptr <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign err_sticky = err_sticky_q;
  assign alu_mode   = mode_q;
  assign alu_in_a   = a_q;
  assign alu_in_b   = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter.
// Each request pushes its expected response (owner, data, err, latency) onto
// a scoreboard queue. The queue is popped when the DUT presents rsp_valid.
// A behavioural ALU model answers alu_valid after the documented latency.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 40;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid, req_ready, rsp_valid, rsp_ack;
  logic [N-1:0][1:0]    req_mode;
  logic [N-1:0][31:0]   req_a, req_b;
  logic [63:0]          rsp_data, alu_out;
  logic                 rsp_err, err_sticky, busy, alu_valid, alu_ready;
  logic [1:0]           alu_mode;
  logic [31:0]          alu_in_a, alu_in_b;

  alu_share_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ack    (rsp_ack),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .err_sticky (err_sticky),
    .busy       (busy),
    .alu_valid  (alu_valid),
    .alu_mode   (alu_mode),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_ready  (alu_ready),
    .alu_out    (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [1:0] m, input logic [31:0] a,
                                        input logic [31:0] b);
    case (m)
      OP_MULU: return {32'd0, a} * {32'd0, b};
      OP_DIVU: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      OP_AND:  return {32'd0, a & b};
      default: return {32'd0, a | b};
    endcase
  endfunction

  // Behavioural ALU. Setting alu_dead suppresses the ready pulse.
  logic        alu_dead;
  int          alu_cnt;
  logic [63:0] alu_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt   <= 0;
      alu_ready <= 1'b0;
      alu_out   <= '0;
      alu_res   <= '0;
    end else begin
      alu_ready <= 1'b0;
      alu_out   <= '0;
      if (alu_valid) begin
        alu_cnt <= (alu_mode == OP_MULU || alu_mode == OP_DIVU) ? ALU_LAT_MULDIV - 1
                                                                : ALU_LAT_LOGIC - 1;
        alu_res <= model(alu_mode, alu_in_a, alu_in_b);
      end else if (alu_cnt > 0) begin
        alu_cnt <= alu_cnt - 1;
        if (alu_cnt == 1 && !alu_dead) begin
          alu_ready <= 1'b1;
          alu_out   <= alu_res;
        end
      end
    end
  end

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]   model_ptr, model_owner, accept_owner;
  logic         model_busy, resp_active, hold_ack, pend_ack, pend_accept;
  logic [N-1:0] pend_drop;
  logic [63:0]  held_data;
  int           acc_cyc[N];
  int           acc_count[N];
  int           ack_cyc;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [1:0] idxOf(input logic [N-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] expWinner(input logic [N-1:0] v, input logic [1:0] p);
    logic [1:0] k;
    k = p;
    for (int s = 0; s < N; s++) begin
      if (v[k]) return k;
      k = k + 2'd1;
    end
    return p;
  endfunction

  task automatic applyStimulus(input logic [1:0] idx, input logic [1:0] m,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_data);
    exp_t e;
    req_mode[idx]  = m;
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_valid[idx] = 1'b1;
    e.idx  = int'(idx);
    e.err  = alu_dead;
    e.data = alu_dead ? 64'd0 : exp_data;
    e.lat  = alu_dead ? 2 + TMO : ((m == OP_MULU || m == OP_DIVU) ? 35 : 4);
    exp_q.push_back(e);
  endtask

  // Sampled on the falling edge, away from the active clock edge.
  task automatic monitor();
    logic [1:0]   a;
    logic [1:0]   w;
    logic [N-1:0] oh;
    int           found;
    exp_t         e;
    if (rsp_valid != '0) begin
      oh = 4'b0001 << model_owner;
      if (!resp_active) begin
        checkOutput("rsp_owner", rsp_valid, oh);
        found = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (found < 0 && exp_q[i].idx == int'(model_owner)) found = i;
        if (found < 0) begin
          checkOutput("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q[found];
          exp_q.delete(found);
          checkOutput("rsp_data", rsp_data, e.data);
          checkOutput("rsp_err", rsp_err, e.err);
          checkOutput("rsp_latency", cyc - acc_cyc[model_owner], e.lat);
        end
        resp_active = 1'b1;
        held_data   = rsp_data;
      end else if (hold_ack) begin
        checkOutput("hold_data", rsp_data, held_data);
        checkOutput("hold_no_ready", req_ready, 0);
      end
      if (hold_ack) begin
        rsp_ack = ~oh;
      end else begin
        rsp_ack  = oh;
        pend_ack = 1'b1;
        ack_cyc  = cyc;
      end
    end
    if (req_ready != '0 || (!model_busy && req_valid != '0)) begin
      if (model_busy) begin
        checkOutput("ready_while_busy", req_ready, 0);
      end else begin
        w = expWinner(req_valid, model_ptr);
        checkOutput("grant", req_ready, 4'b0001 << w);
        if ((req_ready & req_valid) != '0) begin
          a = idxOf(req_ready & req_valid);
          if (grant_q.size() > 0) checkOutput("grant_order", a, grant_q.pop_front());
          acc_cyc[a]   = cyc;
          acc_count[a] = acc_count[a] + 1;
          pend_drop[a] = 1'b1;
          pend_accept  = 1'b1;
          accept_owner = a;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) monitor();
    @(posedge clk);
    #1;
    if (pend_ack) begin
      model_ptr   = model_owner + 2'd1;
      model_busy  = 1'b0;
      resp_active = 1'b0;
      pend_ack    = 1'b0;
    end
    rsp_ack = '0;
    if (pend_accept) begin
      model_owner = accept_owner;
      model_busy  = 1'b1;
      pend_accept = 1'b0;
    end
    req_valid = req_valid & ~pend_drop;
    pend_drop = '0;
  endtask

  task automatic waitAccept(input logic [1:0] idx, input int budget);
    int target;
    int k;
    target = acc_count[idx] + 1;
    k = 0;
    while (acc_count[idx] < target && k < budget) begin
      tick();
      k++;
    end
    checkOutput("accept_wait", acc_count[idx], target);
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || model_busy) && k < budget) begin
      tick();
      k++;
    end
    checkOutput("drain", exp_q.size(), 0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ctl"},
                {req_ready, rsp_valid, rsp_err, err_sticky, busy, alu_valid, alu_mode}, 0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 0);
    checkOutput({tag, "_alu_ops"}, {alu_in_a, alu_in_b}, 0);
  endtask

  task automatic clearBench();
    req_valid   = '0;
    rsp_ack     = '0;
    pend_drop   = '0;
    pend_ack    = 1'b0;
    pend_accept = 1'b0;
    model_ptr   = '0;
    model_owner = '0;
    model_busy  = 1'b0;
    resp_active = 1'b0;
    hold_ack    = 1'b0;
    exp_q.delete();
    grant_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    req_mode = '0;
    req_a    = '0;
    req_b    = '0;
    alu_dead = 1'b0;
    ack_cyc  = 0;
    held_data = '0;
    accept_owner = '0;
    for (int i = 0; i < N; i++) begin
      acc_cyc[i]   = 0;
      acc_count[i] = 0;
    end
    clearBench();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("por");

    // Four and-requests held from reset: grants must come out 0,1,2,3.
    for (int i = 0; i < N; i++) begin
      grant_q.push_back(i);
      applyStimulus(2'(i), OP_AND, 32'hFFFF_0000 | 32'(i * 17), 32'h00FF_00FF,
                    model(OP_AND, 32'hFFFF_0000 | 32'(i * 17), 32'h00FF_00FF));
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitDrain(300);

    // Only 1 and 3 active. Requester 1 re-requests while its own op is pending.
    grant_q.push_back(1);
    grant_q.push_back(3);
    grant_q.push_back(1);
    applyStimulus(2'd1, OP_OR,  32'h1200_0034, 32'h0056_7800, 64'h0000_0000_1256_7834);
    applyStimulus(2'd3, OP_AND, 32'hDEAD_BEEF, 32'h0000_FFFF, 64'h0000_0000_0000_BEEF);
    waitAccept(2'd1, 20);
    applyStimulus(2'd1, OP_MULU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
    waitDrain(300);

    // Documented vectors: mulu on 2, divu on 0, and on 1.
    applyStimulus(2'd2, OP_MULU, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
    waitDrain(100);
    applyStimulus(2'd0, OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    waitDrain(100);
    applyStimulus(2'd1, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0);
    waitDrain(100);

    // Backpressure: hold the response for 10 cycles while others request.
    grant_q.push_back(3);
    grant_q.push_back(0);
    grant_q.push_back(1);
    hold_ack = 1'b1;
    applyStimulus(2'd3, OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 64'h0000_0000_A5A5_5A5A);
    waitAccept(2'd3, 20);
    applyStimulus(2'd0, OP_DIVU, 32'd1000, 32'd3, {32'd1, 32'd333});
    applyStimulus(2'd1, OP_AND, 32'h1234_5678, 32'hFF00_FF00, 64'h0000_0000_1200_5600);
    k = 0;
    while (!resp_active && k < 50) begin
      tick();
      k++;
    end
    checkOutput("hold_resp_seen", resp_active, 1'b1);
    repeat (10) tick();
    hold_ack = 1'b0;
    waitAccept(2'd0, 20);
    checkOutput("grant_after_ack", acc_cyc[0], ack_cyc + 1);
    waitDrain(300);

    // Timeout: the ALU never answers.
    alu_dead = 1'b1;
    applyStimulus(2'd2, OP_MULU, 32'd5, 32'd6, 64'd30);
    waitDrain(200);
    alu_dead = 1'b0;
    checkOutput("err_sticky_set", err_sticky, 1'b1);
    applyStimulus(2'd1, OP_AND, 32'h0000_00FF, 32'h0000_0F0F, 64'h0000_0000_0000_000F);
    waitDrain(100);
    checkOutput("err_sticky_held", err_sticky, 1'b1);

    // Reset in the middle of a mulu WAIT, then check rr_ptr restarts at 0.
    applyStimulus(2'd2, OP_MULU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    waitAccept(2'd2, 20);
    repeat (10) tick();
    checkOutput("busy_mid_op", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkReset("mid");
    clearBench();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_q.push_back(0);
    grant_q.push_back(3);
    applyStimulus(2'd0, OP_AND, 32'h0F0F_0F0F, 32'hFFFF_0000, 64'h0000_0000_0F0F_0000);
    applyStimulus(2'd3, OP_DIVU, 32'd50, 32'd8, {32'd2, 32'd6});
    waitDrain(200);

    $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
